d_mem: RTL and testbench
========================

D_MEM -- requirements
Module: d_mem

Interface
REQ-001 Parameter DEPTH, default 1024, number of 32-bit words held.
REQ-002 Parameter AW, default 10, word-index width; AW = log2(DEPTH).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 DM_CS  input  1  chip select; no read or write occurs unless high.
REQ-006 DM_R  input  1  read enable.
REQ-007 DM_W  input  1  write enable.
REQ-008 addr  input  32  byte address.
REQ-009 data_in  input  32  write data.
REQ-010 data_out  output  32  read data.

Function
REQ-011 Storage SHALL be DEPTH words of 32 bits, word-addressed by index = addr[AW+1:2].
REQ-012 addr[1:0] SHALL be ignored: no byte or halfword access, no misalignment fault.
REQ-013 addr[31:AW+2] SHALL be ignored, so upper addresses alias modulo DEPTH*4 bytes.
REQ-014 Write SHALL occur at the rising clk edge when DM_CS=1, DM_W=1 and rst=0: mem[index] <= data_in, all 32 bits.
REQ-015 Read SHALL be combinational with zero latency: data_out = mem[index] while DM_CS=1, DM_R=1 and rst=0.
REQ-016 data_out SHALL be 32'h0 whenever DM_CS=0, DM_R=0 or rst=1.
REQ-017 DM_W without DM_CS SHALL NOT modify memory.
REQ-018 DM_R=1 and DM_W=1 on the same address in the same cycle:
- data_out shows the old word before the edge.
- data_out shows data_in immediately after the edge.
- No forwarding path.
REQ-019 Back-to-back writes to different addresses on consecutive edges SHALL all complete; there is no busy state and no handshake.
REQ-020 Changing addr, data_in or the enables between edges SHALL have no effect on stored contents.
REQ-021 Memory contents SHALL be undefined (X in simulation) before the first write, unless cleared per REQ-024.

Reset
REQ-022 While rst=1 at a rising edge, no write SHALL occur, even if DM_CS=1 and DM_W=1.
REQ-023 data_out SHALL read 0 while rst=1 (REQ-016). Storage retention under reset is set by REQ-024/REQ-025.

Configuration
REQ-024 Macro D_MEM_CLEAR_EN defined: each rising edge with rst=1 SHALL set every word to 32'h0.
REQ-025 Macro D_MEM_CLEAR_EN undefined: reset SHALL leave memory contents unchanged, and the array SHALL be inferable as plain block RAM with no clear logic.

Verification
REQ-026 Write then read, byte address 920:
- rst=0, CS=R=W=1, addr=920, data_in=32'hFF, one edge.
- Then W=0: data_out=32'h000000FF, from word index 230.
REQ-027 Aliasing and independent words:
- Write 32'hFF at addr 12, then 32'hA5A5A5A5 at addr 0.
- Reading addr 12 returns 32'hFF; addr 0 returns 32'hA5A5A5A5.
- Reading addr 4096+12 returns 32'hFF (alias).
REQ-028 Gating:
- CS=0, W=1, addr=12, data_in=32'h1234, one edge: memory unchanged.
- With CS=0, R=1: data_out=0.
- Then CS=1, R=1: addr 12 reads 32'hFF.
REQ-029 Simultaneous read/write:
- addr 920 holds 32'hFF; CS=R=W=1, data_in=32'h55.
- data_out=32'hFF before the edge, 32'h55 after it.
- addr=921 also reads 32'h55 (low bits ignored).
REQ-030 Reset:
- Assert rst=1 with CS=W=1, data_in=32'hDEAD, one edge.
- data_out=0 during reset; after release, no write has occurred.
- With D_MEM_CLEAR_EN: addr 920 reads 0.
- Without D_MEM_CLEAR_EN: addr 920 reads its pre-reset value.

Source files
------------

// File: rtl/d_mem.sv
// ---------------------------------------------------------------------------
// d_mem : single-port, word-organised data memory.
//
// Holds DEPTH 32-bit words and is addressed with a byte address. Only the
// word index addr[AW+1:2] selects the word. The two byte-offset bits and
// everything above the index are dropped, so upper addresses alias modulo
// DEPTH*4 bytes and unaligned addresses simply hit the containing word.
//
// Writes take effect on the rising edge of clk. Reads are combinational
// (zero latency) and see the array contents as they are before that edge.
// A read and a write to the same word in one cycle therefore return the old
// word until the edge and the new word after it. There is no bypass path.
//
// Optional feature (compile-time macro):
//   D_MEM_CLEAR_EN  defined   : every rising edge with rst=1 zeroes all words.
//                   undefined : reset leaves the array untouched, so the array
//                               stays a plain RAM with no clear logic.
//
// Ports:
//   clk       in   1   clock, rising edge
//   rst       in   1   synchronous, active-high reset
//   DM_CS     in   1   chip select; gates both read and write
//   DM_R      in   1   read enable
//   DM_W      in   1   write enable
//   addr      in  32   byte address
//   data_in   in  32   write data, always a full 32-bit word
//   data_out  out 32   read data; 0 unless CS & R & !rst
// ---------------------------------------------------------------------------
module d_mem #(
   parameter int DEPTH = 1024,
   parameter int AW    = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        DM_CS,
   input  logic        DM_R,
   input  logic        DM_W,
   input  logic [31:0] addr,
   input  logic [31:0] data_in,
   output logic [31:0] data_out
);

   logic [31:0]   mem_q [DEPTH];
   logic [AW-1:0] idx;
   logic          wr_en;
   logic          rd_en;

   // Address bits outside the word index carry no meaning here.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{addr[31:AW+2], addr[1:0]};

   always_comb begin
      idx      = addr[AW+1:2];
      wr_en    = DM_CS & DM_W & ~rst;
      rd_en    = DM_CS & DM_R & ~rst;
      data_out = rd_en ? mem_q[idx] : 32'h0;
   end

`ifdef D_MEM_CLEAR_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= 32'h0;
      end else if (wr_en) begin
         mem_q[idx] <= data_in;
      end
   end
`else
   // Reset is already folded into wr_en, so the array has a single write
   // port and no clear path.
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[idx] <= data_in;
   end
`endif

endmodule

// File: tb/tb_d_mem.sv
module tb_d_mem;
   localparam int DEPTH = 1024;
   localparam int AW    = 10;

   logic        clk = 1'b0;
   logic        rst, cs, r, w;
   logic [31:0] addr, din, dout;

   always #5 clk = ~clk;

   d_mem #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk(clk), .rst(rst), .DM_CS(cs), .DM_R(r), .DM_W(w),
      .addr(addr), .data_in(din), .data_out(dout)
   );

   // Reference model: the known contents, keyed by word index. A word that
   // is absent has never been written, so reading it is undefined and is
   // not checked.
   logic [31:0] model [int];
   logic [31:0] exp_q [$];
   string       name_q [$];
   bit          chk_vld = 1'b0;
   int          checks = 0, failures = 0;

   function automatic int widx(input logic [31:0] a);
      return int'(a[31:2] % 32'(DEPTH));
   endfunction

   // One clock cycle of stimulus. The expected read data comes from the
   // pre-edge model, and the model is updated after the edge.
   task automatic op(input bit rs, input bit c, input bit rd, input bit wr,
                     input logic [31:0] a, input logic [31:0] d, input string nm);
      rst = rs; cs = c; r = rd; w = wr; addr = a; din = d;
      if (!(c && rd && !rs)) begin
         exp_q.push_back(32'h0); name_q.push_back(nm); chk_vld = 1'b1;
      end else if (model.exists(widx(a))) begin
         exp_q.push_back(model[widx(a)]); name_q.push_back(nm); chk_vld = 1'b1;
      end
      @(posedge clk);
`ifdef D_MEM_CLEAR_EN
      if (rs) for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
`endif
      if (!rs && c && wr) model[widx(a)] = d;
      #1 chk_vld = 1'b0;
   endtask

   // Monitor: samples data_out mid-cycle whenever a read result is presented.
   logic [31:0] m_exp;
   string       m_nm;
   always @(negedge clk) begin
      if (chk_vld) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_underflow got=%h", dout);
         end else begin
            m_exp = exp_q.pop_front();
            m_nm  = name_q.pop_front();
            if (dout !== m_exp) begin
               failures++;
               $display("FAIL %s addr=%h got=%h exp=%h", m_nm, addr, dout, m_exp);
            end
         end
      end
   end

   initial begin
      logic [31:0] a;
      rst = 1'b1; cs = 1'b0; r = 1'b0; w = 1'b0; addr = '0; din = '0;
      @(posedge clk); #1;

      op(1, 0, 0, 0, 32'd0,   32'h0,  "reset_idle");
      op(1, 1, 1, 0, 32'd920, 32'h0,  "reset_read");

      // write then read back at byte 920 (word 230)
      op(0, 1, 1, 1, 32'd920, 32'hFF, "wr920");
      op(0, 1, 1, 0, 32'd920, 32'h0,  "rd920");

      // independent words and aliasing
      op(0, 1, 0, 1, 32'd12,  32'hFF,       "wr12_nord");
      op(0, 1, 0, 1, 32'd0,   32'hA5A5A5A5, "wr0_nord");
      op(0, 1, 1, 0, 32'd12,  32'h0,  "rd12");
      op(0, 1, 1, 0, 32'd0,   32'h0,  "rd0");
      op(0, 1, 1, 0, 32'd4108, 32'h0, "rd12_alias");

      // gating by chip select
      op(0, 0, 0, 1, 32'd12,  32'h1234, "cs0_wr");
      op(0, 0, 1, 0, 32'd12,  32'h0,  "cs0_rd");
      op(0, 1, 1, 0, 32'd12,  32'h0,  "rd12_after_cs0");

      // simultaneous read and write to the same word
      op(0, 1, 1, 1, 32'd920, 32'h55, "rw_before_edge");
      op(0, 1, 1, 0, 32'd920, 32'h0,  "rw_after_edge");
      op(0, 1, 1, 0, 32'd921, 32'h0,  "rw_low_bits");

      // reset blocks writes (and clears memory when the macro is defined)
      op(1, 1, 1, 1, 32'd920, 32'hDEAD, "rst_wr_out");
      op(0, 1, 1, 0, 32'd920, 32'h0,  "post_rst_920");
      op(0, 1, 1, 0, 32'd12,  32'h0,  "post_rst_12");

      // randomized traffic over a small index set with aliased upper bits
      for (int n = 0; n < 600; n++) begin
         a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3))
           | (32'($urandom_range(0, 3)) << 12);
         if ($urandom_range(0, 9) == 0) a = $urandom;
         op($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
            a, $urandom, "random");
      end

      cs = 1'b0; r = 1'b0; w = 1'b0; rst = 1'b0;
      repeat (2) @(posedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain left=%0d exp=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
